// File: rtl/freq_gen.sv
// freq_gen: button-stepped 0..9 square-wave generator with 7-segment readout.
// Half-period is HALF_BASE >> sel clk cycles; each button is synchronized and debounced.
module freq_gen #(
    parameter int HALF_BASE  = 512,
    parameter int DEB_CYCLES = 1000,
    parameter int CNT_W      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic       sig,
    output logic [6:0] segments
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
    localparam logic [CNT_W:0] HB = (CNT_W + 1)'(HALF_BASE);
    localparam logic [CNT_W:0] ONE = (CNT_W + 1)'(1);

    logic [1:0] s1_q, s2_q, lvl_q, lvl, pulse;
    logic [3:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0] half_s, half;
    logic sig_q, sig_d, up, dn, wrap;

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [DW-1:0] deb_q, deb_d;
        assign deb_d = !s2_q[b] ? '0 : deb_q == DEB_MAX ? deb_q : deb_q + DW'(1);
        assign lvl[b] = deb_q == DEB_MAX;
        always_ff @(posedge clk or posedge rst)
            if (rst) deb_q <= '0;
            else deb_q <= deb_d;
    end

    assign pulse = lvl & ~lvl_q;
    assign up = pulse[0] & ~pulse[1] & (sel_q != 4'd9);
    assign dn = pulse[1] & ~pulse[0] & (sel_q != 4'd0);
    assign sel_d = up ? sel_q + 4'd1 : dn ? sel_q - 4'd1 : sel_q;

    // A zero half-period (small HALF_BASE at high settings) behaves as 1: toggle every cycle.
    assign half_s = HB >> sel_q;
    assign half = half_s == '0 ? ONE : half_s;
    assign wrap = {1'b0, cnt_q} == half - ONE;
    assign cnt_d = (up | dn | wrap) ? '0 : cnt_q + CNT_W'(1);
    assign sig_d = (up | dn) ? sig_q : sig_q ^ wrap;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            lvl_q <= '0;
            sel_q <= '0;
            cnt_q <= '0;
            sig_q <= 1'b0;
        end else begin
            s1_q  <= {btn_dn, btn_up};
            s2_q  <= s1_q;
            lvl_q <= lvl;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            sig_q <= sig_d;
        end

    always_comb begin
        case (sel_q)
            4'd0:    segments = 7'h3F;
            4'd1:    segments = 7'h06;
            4'd2:    segments = 7'h5B;
            4'd3:    segments = 7'h4F;
            4'd4:    segments = 7'h66;
            4'd5:    segments = 7'h6D;
            4'd6:    segments = 7'h7D;
            4'd7:    segments = 7'h07;
            4'd8:    segments = 7'h7F;
            4'd9:    segments = 7'h6F;
            default: segments = 7'h00;
        endcase
    end

    assign sig = sig_q;
endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: randomized self-checking bench for freq_gen (HALF_BASE=16, DEB_CYCLES=4).
module tb_freq_gen;
    logic clk = 1'b0, rst = 1'b1, btn_up = 1'b0, btn_dn = 1'b0;
    logic sig;
    logic [6:0] segments;
    int checks = 0, errors = 0, sel_m = 0, seg_changes = 0;
    logic [6:0] seg_prev = 7'h3F;

    freq_gen #(.HALF_BASE(16), .DEB_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .sig(sig), .segments(segments)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (segments !== seg_prev) seg_changes <= seg_changes + 1;
        seg_prev <= segments;
    end

    function automatic int half_of(input int s);
        int h;
        h = 16 >> s;
        return h < 1 ? 1 : h;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    task automatic wait_toggle(output int n);
        logic s;
        s = sig;
        n = 0;
        while (sig === s) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                n = -1;
                return;
            end
        end
    endtask

    task automatic press(input logic u, input logic d, input int hold, input int gap);
        @(negedge clk);
        btn_up = u;
        btn_dn = d;
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (gap) @(negedge clk);
        if (u && !d && sel_m < 9) sel_m++;
        if (d && !u && sel_m > 0) sel_m--;
    endtask

    task automatic test_reset;
        int n, a, b;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sig !== 1'b0) begin errors++; $display("FAIL reset_sig got %b want 0", sig); end
        checks++;
        if (segments !== 7'h3F) begin errors++; $display("FAIL reset_seg got %h want 3f", segments); end
        rst = 1'b0;
        sel_m = 0;
        wait_toggle(n);
        checks++;
        if (n != 16 || sig !== 1'b1) begin errors++; $display("FAIL first_rise got %0d cycles sig=%b want 16 sig=1", n, sig); end
        for (int i = 0; i < 10; i++) begin
            wait_toggle(a);
            wait_toggle(b);
            checks++;
            if (a + b != 32) begin errors++; $display("FAIL period0 #%0d got %0d+%0d want 32", i, a, b); end
        end
    endtask

    task automatic test_up_presses;
        int c0, a, b;
        c0 = seg_changes;
        repeat (3) press(1'b1, 1'b0, 10, 10);
        checks++;
        if (segments !== seg_of(3)) begin errors++; $display("FAIL up3_seg got %h want %h", segments, seg_of(3)); end
        checks++;
        if (seg_changes - c0 != 3) begin errors++; $display("FAIL up3_count got %0d want 3", seg_changes - c0); end
        wait_toggle(a);
        wait_toggle(a);
        wait_toggle(b);
        checks++;
        if (a + b != 4) begin errors++; $display("FAIL up3_period got %0d want 4", a + b); end
    endtask

    task automatic test_glitch;
        int c0;
        c0 = seg_changes;
        press(1'b1, 1'b0, 3, 10);
        checks++;
        if (segments !== seg_of(sel_m - 1) || seg_changes != c0) begin
            errors++;
            $display("FAIL glitch_only got seg=%h changes=%0d want seg=%h changes=0", segments, seg_changes - c0, seg_of(sel_m - 1));
        end
        sel_m--;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        btn_up = 1'b0;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        sel_m++;
        checks++;
        if (segments !== seg_of(sel_m) || seg_changes - c0 != 1) begin
            errors++;
            $display("FAIL glitch_press got seg=%h changes=%0d want seg=%h changes=1", segments, seg_changes - c0, seg_of(sel_m));
        end
    endtask

    task automatic test_saturation;
        logic s;
        repeat (12) press(1'b1, 1'b0, 6, 5);
        checks++;
        if (sel_m != 9 || segments !== 7'h6F) begin errors++; $display("FAIL sat_up got %h want 6f", segments); end
        for (int i = 0; i < 6; i++) begin
            s = sig;
            @(posedge clk);
            #1;
            checks++;
            if (sig === s) begin errors++; $display("FAIL sat_toggle #%0d got sig=%b want %b", i, sig, ~s); end
        end
        repeat (12) press(1'b0, 1'b1, 6, 5);
        checks++;
        if (sel_m != 0 || segments !== 7'h3F) begin errors++; $display("FAIL sat_dn got %h want 3f", segments); end
    endtask

    task automatic test_same_cycle;
        int c0, n, tgt;
        logic prev;
        logic found;
        repeat (2) press(1'b1, 1'b0, 8, 6);
        c0 = seg_changes;
        press(1'b1, 1'b1, 8, 8);
        checks++;
        if (segments !== seg_of(2) || seg_changes != c0) begin
            errors++;
            $display("FAIL both_pressed got seg=%h changes=%0d want seg=%h changes=0", segments, seg_changes - c0, seg_of(2));
        end
        for (int k = 0; k < 2; k++) begin
            tgt = k == 0 ? sel_m + 1 : sel_m - 1;
            @(negedge clk);
            if (k == 0) btn_up = 1'b1;
            else btn_dn = 1'b1;
            prev = sig;
            found = 1'b0;
            for (int c = 0; c < 30 && !found; c++) begin
                @(posedge clk);
                #1;
                if (segments !== seg_of(sel_m)) begin
                    found = 1'b1;
                    checks++;
                    if (segments !== seg_of(tgt) || sig !== prev) begin
                        errors++;
                        $display("FAIL update_cycle dir=%0d got seg=%h sig=%b want seg=%h sig=%b", k, segments, sig, seg_of(tgt), prev);
                    end
                end
                prev = sig;
            end
            checks++;
            if (!found) begin errors++; $display("FAIL update_timeout dir=%0d got no change want change", k); end
            sel_m = tgt;
            wait_toggle(n);
            checks++;
            if (n != half_of(sel_m)) begin errors++; $display("FAIL new_half dir=%0d got %0d want %0d", k, n, half_of(sel_m)); end
            @(negedge clk);
            btn_up = 1'b0;
            btn_dn = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_random;
        int op, a, b;
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 2);
            press(op != 1, op != 0, $urandom_range(5, 12), $urandom_range(4, 10));
            checks++;
            if (segments !== seg_of(sel_m)) begin errors++; $display("FAIL rand_seg #%0d op=%0d got %h want %h", i, op, segments, seg_of(sel_m)); end
        end
        wait_toggle(a);
        wait_toggle(a);
        wait_toggle(b);
        checks++;
        if (a + b != 2 * half_of(sel_m)) begin errors++; $display("FAIL rand_period got %0d want %0d", a + b, 2 * half_of(sel_m)); end
    endtask

    task automatic test_async_reset;
        int n, a, b;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sel_m = 0;
        repeat (5) press(1'b1, 1'b0, 6, 5);
        checks++;
        if (segments !== 7'h6D) begin errors++; $display("FAIL sel5_seg got %h want 6d", segments); end
        for (int c = 0; c < 10 && sig !== 1'b1; c++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sig !== 1'b0 || segments !== 7'h3F) begin
            errors++;
            $display("FAIL async_reset got sig=%b seg=%h want sig=0 seg=3f", sig, segments);
        end
        @(negedge clk);
        rst = 1'b0;
        sel_m = 0;
        wait_toggle(n);
        checks++;
        if (n != 16) begin errors++; $display("FAIL post_reset_rise got %0d want 16", n); end
        for (int i = 0; i < 2; i++) begin
            wait_toggle(a);
            wait_toggle(b);
            checks++;
            if (a + b != 32) begin errors++; $display("FAIL post_reset_period got %0d want 32", a + b); end
        end
        @(negedge clk);
        rst = 1'b1;
        btn_up = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (segments !== 7'h3F) begin errors++; $display("FAIL held_early got %h want 3f", segments); end
        repeat (9) @(negedge clk);
        checks++;
        if (segments !== 7'h06) begin errors++; $display("FAIL held_pulse got %h want 06", segments); end
        repeat (30) @(negedge clk);
        checks++;
        if (segments !== 7'h06) begin errors++; $display("FAIL held_repeat got %h want 06", segments); end
        btn_up = 1'b0;
    endtask

    initial begin
        test_reset;
        test_up_presses;
        test_glitch;
        test_saturation;
        test_same_cycle;
        test_random;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
